// File: rtl/ddco_pkg.sv
// rtl/ddco_pkg.sv - shared constants and state encoding for the serial subtractor
//
// Purpose : holds the default operand width and the FSM state type used by
//           serial_subtractor.
// Contents: DEFAULT_WIDTH  - default operand/result width in bits
//           state_t        - IDLE / RUN / DONE state encoding
package ddco_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : ddco_pkg

// File: rtl/fullsub.sv
// rtl/fullsub.sv - one-bit combinational full subtractor
//
// Purpose: computes one bit of x - y - bin.
// Ports  : x    in  minuend bit
//          y    in  subtrahend bit
//          bin  in  borrow in
//          d    out difference bit
//          bout out borrow out
module fullsub (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : fullsub

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first
//
// Purpose: computes (a - b) mod 2^WIDTH and the final borrow, one bit per clock.
// Ports  : clk   in  clock, rising edge
//          rst_n in  asynchronous active-low reset
//          start in  begin a subtraction (honoured in IDLE only)
//          a     in  minuend, sampled on accepted start
//          b     in  subtrahend, sampled on accepted start
//          busy  out high during the WIDTH RUN cycles
//          done  out one-cycle pulse, diff/bout valid
//          diff  out result, held until the next accepted start
//          bout  out final borrow (a < b), held like diff
module serial_subtractor
   import ddco_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int CW = $clog2(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             borrow_q, borrow_d;
   logic             bout_q, bout_d;
   logic             bit_d, bit_b;

   fullsub u_fullsub (
      .x    (a_sh_q[0]),
      .y    (b_sh_q[0]),
      .bin  (borrow_q),
      .d    (bit_d),
      .bout (bit_b)
   );

   // The minuend register doubles as the result register: each cycle one
   // minuend bit leaves at the LSB and one difference bit enters at the MSB.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      busy     = 1'b0;
      done     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end

         RUN: begin
            busy     = 1'b1;
            a_sh_d   = {bit_d, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            borrow_d = bit_b;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Last bit: publish into the held output registers so diff
               // never shows partial results while RUN is in progress.
               diff_d  = {bit_d, a_sh_q[WIDTH-1:1]};
               bout_d  = bit_b;
               cnt_d   = '0;
               state_d = DONE;
            end
         end

         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor and fullsub
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;

   logic fx, fy, fbin, fd, fbout;

   int total;
   int bad;

   logic [W:0] sb_q[$];
   logic [W:0] exp_v;
   logic [W:0] last_exp;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
   );

   fullsub u_fs (
      .x    (fx),
      .y    (fy),
      .bin  (fbin),
      .d    (fd),
      .bout (fbout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
      logic [W-1:0] d;
      d = W'((int'(ma) - int'(mb) + (1 << W)) % (1 << W));
      return {(int'(ma) < int'(mb)), d};
   endfunction

   // One operation: start for one cycle, then watch 20 cycles. At RUN cycle
   // ignore_at (if nonzero) a stray start with zero operands is pulsed.
   task automatic do_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input int ignore_at);
      int nbusy;
      int ndone;
      int done_at;
      @(negedge clk);
      a = ta;
      b = tb;
      start = 1'b1;
      sb_q.push_back(model(ta, tb));
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      ndone = 0;
      done_at = 0;
      for (int k = 1; k <= 20; k++) begin
         if (busy) nbusy++;
         if (busy && done) chk({tag, "_busy_and_done"}, 1, 0);
         if (done) begin
            ndone++;
            done_at = k;
            if (sb_q.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
            else begin
               exp_v = sb_q.pop_front();
               last_exp = exp_v;
               chk({tag, "_diff"}, 32'(diff), 32'(exp_v[W-1:0]));
               chk({tag, "_bout"}, 32'(bout), 32'(exp_v[W]));
            end
         end
         start = (ignore_at != 0 && k == ignore_at) ? 1'b1 : 1'b0;
         if (start) begin
            a = '0;
            b = '0;
         end else begin
            a = W'($urandom);
            b = W'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(nbusy), W);
      chk({tag, "_done_count"}, 32'(ndone), 1);
      chk({tag, "_done_cycle"}, 32'(done_at), W + 1);
      chk({tag, "_hold_diff"}, 32'(diff), 32'(last_exp[W-1:0]));
      chk({tag, "_hold_bout"}, 32'(bout), 32'(last_exp[W]));
   endtask

   initial begin
      int d1, d2, nd;
      int sval;
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0;
      b = '0;
      fx = 1'b0;
      fy = 1'b0;
      fbin = 1'b0;
      last_exp = '0;

      // fullsub truth table via signed arithmetic x - y - bin
      for (int i = 0; i < 8; i++) begin
         fx = i[2];
         fy = i[1];
         fbin = i[0];
         #1;
         sval = int'(fx) - int'(fy) - int'(fbin);
         chk($sformatf("fullsub_d_%0d", i), 32'(fd), 32'(sval & 1));
         chk($sformatf("fullsub_bout_%0d", i), 32'(fbout), 32'(sval < 0));
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_diff", 32'(diff), 0);
      chk("rst_bout", 32'(bout), 0);
      rst_n = 1'b1;

      do_op("op_05_03", 8'h05, 8'h03, 0);
      do_op("op_03_05", 8'h03, 8'h05, 0);
      do_op("op_00_ff", 8'h00, 8'hFF, 0);
      do_op("op_a5_a5", 8'hA5, 8'hA5, 0);
      do_op("op_ff_00", 8'hFF, 8'h00, 0);
      do_op("op_10_01_ignore", 8'h10, 8'h01, 3);
      chk("ignore_sb_empty", 32'(sb_q.size()), 0);

      // Reset mid-RUN, between edges; prior diff is nonzero
      @(negedge clk);
      a = 8'h55;
      b = 8'h11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      chk("arst_diff", 32'(diff), 0);
      chk("arst_bout", 32'(bout), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 12; k++) begin
         if (done || busy) nd++;
         @(negedge clk);
      end
      chk("post_rst_no_activity", 32'(nd), 0);
      do_op("op_20_01_after_rst", 8'h20, 8'h01, 0);

      // Start held high: back-to-back every W+2 cycles
      @(negedge clk);
      a = 8'h07;
      b = 8'h09;
      start = 1'b1;
      sb_q.push_back(model(8'h07, 8'h09));
      sb_q.push_back(model(8'h07, 8'h09));
      d1 = -1;
      d2 = -1;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
            if (sb_q.size() == 0) chk("b2b_sb_empty", 1, 0);
            else begin
               exp_v = sb_q.pop_front();
               chk("b2b_diff", 32'(diff), 32'(exp_v[W-1:0]));
               chk("b2b_bout", 32'(bout), 32'(exp_v[W]));
            end
            if (nd == 2) start = 1'b0;
         end
      end
      chk("b2b_done_count", 32'(nd), 2);
      chk("b2b_period", 32'(d2 - d1), W + 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_subtractor
